// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and constants for the 2-way instruction cache.
// Optional ICACHE_PERF_CNT_EN adds hit/miss counters on the icache top.
package icache_pkg;

   localparam int TAG_W      = 20;
   localparam int INDEX_W    = 7;
   localparam int OFFSET_W   = 5;
   localparam int LINE_W     = 256;
   localparam int LINE_WORDS = 8;
   localparam int WORD_SEL_W = 3;
   localparam int SETS       = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      MISS_AR,
      MISS_R
   } state_e;

   localparam logic VALID       = 1'b1;
   localparam logic HIT_SUCCESS = 1'b1;
   localparam logic HIT_FAIL    = 1'b0;
   localparam logic READY       = 1'b1;

   // Word k of a line sits at bits [32k+31:32k].
   function automatic logic [31:0] line_word(input logic [LINE_W-1:0]     line,
                                             input logic [WORD_SEL_W-1:0] sel);
      return line[{sel, 5'b00000} +: 32];
   endfunction

endpackage

// File: rtl/icache_way.sv
// One way of the cache: 128 entries of valid/tag/line with combinational read
// and a single fill write port. Only the valid bits are reset.
module icache_way
   import icache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] rd_index_i,
   output logic               rd_valid_o,
   output logic [TAG_W-1:0]   rd_tag_o,
   output logic [LINE_W-1:0]  rd_line_o,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] wr_index_i,
   input  logic [TAG_W-1:0]   wr_tag_i,
   input  logic [LINE_W-1:0]  wr_line_i
);

   logic [SETS-1:0]   valid_q, valid_d;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] line_mem [SETS];

   always_comb begin
      valid_d = valid_q;
      if (we_i) valid_d[wr_index_i] = VALID;
   end

   always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
   end

   // Tag/data contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_mem[wr_index_i]  <= wr_tag_i;
         line_mem[wr_index_i] <= wr_line_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_mem[rd_index_i];
   assign rd_line_o  = line_mem[rd_index_i];

endmodule

// File: rtl/icache.sv
// 2-way set-associative read-only instruction cache with LRU replacement and a
// single-beat line refill. ICACHE_PERF_CNT_EN adds hit_cnt_o / miss_cnt_o.
module icache
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_i,
   input  logic [31:0]       virtual_addr_i,
   output logic              hit_o,
   output logic              cpu_inst_valid_o,
   output logic [31:0]       cpu_inst_o,
   input  logic              mem_rvalid_i,
   input  logic              mem_arready_i,
   input  logic [LINE_W-1:0] mem_rdata_i,
   output logic              mem_ren_o,
   output logic              mem_rready_o,
   output logic              mem_arvalid_o,
   output logic [31:0]       mem_araddr_o
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   state_e            state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [SETS-1:0]   lru_q, lru_d;

   logic [TAG_W-1:0]      req_tag;
   logic [INDEX_W-1:0]    req_idx;
   logic [WORD_SEL_W-1:0] req_word;
   logic                  v0, v1, hit0, hit1, any_hit, victim_way, fill;
   logic [TAG_W-1:0]      t0, t1;
   logic [LINE_W-1:0]     l0, l1;

   assign req_tag  = addr_q[31:12];
   assign req_idx  = addr_q[11:5];
   assign req_word = addr_q[4:2];

   assign hit0    = v0 && (t0 == req_tag);
   assign hit1    = v1 && (t1 == req_tag);
   assign any_hit = hit0 || hit1;

   // Fill an empty way first (way0 preferred), otherwise the LRU way.
   assign victim_way = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_q[req_idx]);
   assign fill       = (state_q == MISS_R) && mem_rvalid_i && !rst;

   icache_way u_way0 (
      .clk(clk), .rst(rst), .rd_index_i(req_idx),
      .rd_valid_o(v0), .rd_tag_o(t0), .rd_line_o(l0),
      .we_i(fill && !victim_way), .wr_index_i(req_idx),
      .wr_tag_i(req_tag), .wr_line_i(mem_rdata_i)
   );

   icache_way u_way1 (
      .clk(clk), .rst(rst), .rd_index_i(req_idx),
      .rd_valid_o(v1), .rd_tag_o(t1), .rd_line_o(l1),
      .we_i(fill && victim_way), .wr_index_i(req_idx),
      .wr_tag_i(req_tag), .wr_line_i(mem_rdata_i)
   );

   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      lru_d            = lru_q;
      hit_o            = HIT_FAIL;
      cpu_inst_valid_o = 1'b0;
      cpu_inst_o       = '0;
      mem_ren_o        = 1'b0;
      mem_rready_o     = 1'b0;
      mem_arvalid_o    = 1'b0;
      mem_araddr_o     = '0;
      case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
               addr_d  = virtual_addr_i;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (any_hit) begin
               cpu_inst_valid_o = 1'b1;
               hit_o            = HIT_SUCCESS;
               cpu_inst_o       = line_word(hit1 ? l1 : l0, req_word);
               lru_d[req_idx]   = !hit1;
               state_d          = IDLE;
            end else begin
               state_d = MISS_AR;
            end
         end
         MISS_AR: begin
            mem_ren_o     = 1'b1;
            mem_arvalid_o = 1'b1;
            mem_araddr_o  = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
            if (mem_arready_i) state_d = MISS_R;
         end
         MISS_R: begin
            mem_ren_o    = 1'b1;
            mem_rready_o = READY;
            if (mem_rvalid_i) begin
               cpu_inst_valid_o = 1'b1;
               hit_o            = HIT_FAIL;
               cpu_inst_o       = line_word(mem_rdata_i, req_word);
               lru_d[req_idx]   = !victim_way;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Outputs are forced quiet for the whole reset cycle, including mid-refill.
      if (rst) begin
         cpu_inst_valid_o = 1'b0;
         hit_o            = HIT_FAIL;
         cpu_inst_o       = '0;
         mem_ren_o        = 1'b0;
         mem_rready_o     = 1'b0;
         mem_arvalid_o    = 1'b0;
         mem_araddr_o     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         lru_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lru_q   <= lru_d;
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == LOOKUP) begin
         if (any_hit) hit_cnt_d  = hit_cnt_q + 32'd1;
         else         miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold misses, hits, second-way fill, LRU eviction
// and reset during a refill, with a memory model answering 7 cycles after arvalid.
module tb_icache;
   import icache_pkg::*;

   localparam logic [255:0] LINE = 256'h12345678_91023456_78910234_56789102_34567891_02345678_91023456_78910234;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_req_i;
   logic [31:0]  virtual_addr_i;
   logic         hit_o;
   logic         cpu_inst_valid_o;
   logic [31:0]  cpu_inst_o;
   logic         mem_rvalid_i;
   logic         mem_arready_i;
   logic [255:0] mem_rdata_i;
   logic         mem_ren_o;
   logic         mem_rready_o;
   logic         mem_arvalid_o;
   logic [31:0]  mem_araddr_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_q[$];

   icache dut (
      .clk(clk), .rst(rst), .cpu_req_i(cpu_req_i), .virtual_addr_i(virtual_addr_i),
      .hit_o(hit_o), .cpu_inst_valid_o(cpu_inst_valid_o), .cpu_inst_o(cpu_inst_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_arready_i(mem_arready_i), .mem_rdata_i(mem_rdata_i),
      .mem_ren_o(mem_ren_o), .mem_rready_o(mem_rready_o),
      .mem_arvalid_o(mem_arvalid_o), .mem_araddr_o(mem_araddr_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Issue one fetch; a miss is served by the memory model below.
   task automatic access(input logic [31:0] addr, input logic exp_hit, input logic [31:0] exp_inst);
      int n;
      exp_q.push_back(exp_inst);
      @(negedge clk);
      cpu_req_i      = 1'b1;
      virtual_addr_i = addr;
      @(negedge clk);
      cpu_req_i = 1'b0;
      if (exp_hit) begin
         check("hit_valid", cpu_inst_valid_o, 1);
         check("hit_flag", hit_o, 1);
         check("hit_inst", cpu_inst_o, exp_q.pop_front());
         check("hit_no_ar", mem_arvalid_o, 0);
         @(negedge clk);
         check("hit_pulse", cpu_inst_valid_o, 0);
         check("hit_idle_ar", mem_arvalid_o, 0);
      end else begin
         check("lookup_miss_valid", cpu_inst_valid_o, 0);
         n = 0;
         while (!mem_arvalid_o && n < 10) begin
            @(negedge clk);
            n++;
         end
         check("ar_seen", mem_arvalid_o, 1);
         check("araddr", mem_araddr_o, {addr[31:5], 5'b0});
         check("ar_ren", mem_ren_o, 1);
         for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            // A stray request mid-refill must be ignored.
            cpu_req_i      = (i == 2);
            virtual_addr_i = (i == 2) ? (addr ^ 32'h0000_1004) : addr;
         end
         cpu_req_i    = 1'b0;
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = LINE;
         #1;
         check("r_rready", mem_rready_o, 1);
         check("miss_valid", cpu_inst_valid_o, 1);
         check("miss_flag", hit_o, 0);
         check("miss_inst", cpu_inst_o, exp_q.pop_front());
         @(negedge clk);
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = '0;
         #1;
         check("miss_pulse", cpu_inst_valid_o, 0);
         check("miss_inst_zero", cpu_inst_o, 0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      rst            = 1'b1;
      cpu_req_i      = 1'b0;
      virtual_addr_i = '0;
      mem_rvalid_i   = 1'b0;
      mem_arready_i  = 1'b1;
      mem_rdata_i    = '0;
      do_reset();
      check("rst_valid", cpu_inst_valid_o, 0);
      check("rst_hit", hit_o, 0);
      check("rst_ren", mem_ren_o, 0);
      check("rst_arvalid", mem_arvalid_o, 0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));

      access(32'hDEBAD000, 1'b0, 32'h78910234);
      access(32'h24687570, 1'b0, 32'h56789102);
      access(32'h24687574, 1'b1, 32'h78910234);
      access(32'h33487570, 1'b0, 32'h56789102);
      access(32'h33487574, 1'b1, 32'h78910234);
      access(32'h24687578, 1'b1, 32'h91023456);
      access(32'h33487574, 1'b1, 32'h78910234);
      access(32'h57365570, 1'b0, 32'h56789102);
      access(32'h33487570, 1'b1, 32'h56789102);
      access(32'h24687570, 1'b0, 32'h56789102);
      access(32'hDEBAD01C, 1'b1, 32'h12345678);

      // Reset arrives while the refill waits for read data.
      @(negedge clk);
      cpu_req_i      = 1'b1;
      virtual_addr_i = 32'h0ABCD0C8;
      @(negedge clk);
      cpu_req_i = 1'b0;
      n = 0;
      while (!mem_rready_o && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("rr_in_miss_r", mem_rready_o, 1);
      rst          = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = LINE;
      #1;
      check("rr_valid", cpu_inst_valid_o, 0);
      check("rr_inst", cpu_inst_o, 0);
      check("rr_ren", mem_ren_o, 0);
      check("rr_rready", mem_rready_o, 0);
      @(negedge clk);
      rst          = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      check("rr_state", 32'(dut.state_q), 32'(IDLE));
      check("rr_idle_valid", cpu_inst_valid_o, 0);
      access(32'h0ABCD0C8, 1'b0, 32'h02345678);
      access(32'hDEBAD000, 1'b0, 32'h78910234);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
